// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the data RAM arbiter
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_CPU_RD = 2'd1,
    OWN_DISP   = 2'd2
  } owner_t;

  // A CPU write returns nothing, so it leaves no owner behind
  function automatic owner_t next_owner(input logic cpu_grant,
                                        input logic cpu_we,
                                        input logic disp_grant);
    owner_t o;
    o = OWN_NONE;
    if (disp_grant)
      o = OWN_DISP;
    else if (cpu_grant && !cpu_we)
      o = OWN_CPU_RD;
    return o;
  endfunction

endpackage

// File: rtl/ram_arbiter_starve_counter.sv
// rtl/ram_arbiter_starve_counter.sv - saturating display wait counter
module starve_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] count,
  output logic       sat
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  assign sat = (count == MAX_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= 4'd0;
    else if (clr)
      count <= 4'd0;
    else if (inc && !sat)
      count <= count + 4'd1;
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - CPU / display arbiter for the single-port data RAM
module ram_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              disp_en,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  logic       starve;
  logic       disp_want;
  logic       disp_grant;
  logic       cpu_grant;
  logic [3:0] wait_cnt;
  owner_t     owner;

  // CPU has priority until the display has waited MAX_WAIT cycles
  assign disp_want  = disp_en & disp_req;
  assign disp_grant = disp_want & (starve | !cpu_req);
  assign cpu_grant  = cpu_req & !disp_grant;

  assign cpu_stall = cpu_req & !cpu_grant;
  assign disp_ack  = disp_grant;

  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    if (disp_grant) begin
      ram_address = disp_addr;
    end else if (cpu_grant) begin
      ram_address = cpu_addr;
      ram_data    = cpu_wdata;
      ram_wren    = cpu_we;
    end
  end

  starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (disp_want & !disp_grant),
    .clr   (disp_grant | !disp_en),
    .count (wait_cnt),
    .sat   (starve)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      owner <= OWN_NONE;
    else
      owner <= next_owner(cpu_grant, cpu_we, disp_grant);
  end

  // Both read ports see the RAM output; the owner decides who it belongs to
  assign cpu_rvalid  = (owner == OWN_CPU_RD);
  assign disp_rvalid = (owner == OWN_DISP);
  assign cpu_rdata   = ram_q;
  assign disp_rdata  = ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed scoreboard bench for ram_arbiter
module tb_ram_arbiter;

  localparam int K_NONE = 0;
  localparam int K_CPU  = 1;
  localparam int K_DISP = 2;

  typedef struct {
    int          kind;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_stall;
  logic [15:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        disp_en = 1'b0;
  logic        disp_req = 1'b0;
  logic [15:0] disp_addr = '0;
  logic        disp_ack;
  logic [15:0] disp_rdata;
  logic        disp_rvalid;
  logic [15:0] ram_address;
  logic [15:0] ram_data;
  logic        ram_wren;
  logic [15:0] ram_q = '0;

  logic [15:0] mem [0:65535];
  logic        mem_loaded = 1'b0;
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  ram_arbiter #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .MAX_WAIT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_stall   (cpu_stall),
    .cpu_rdata   (cpu_rdata),
    .cpu_rvalid  (cpu_rvalid),
    .disp_en     (disp_en),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_ack    (disp_ack),
    .disp_rdata  (disp_rdata),
    .disp_rvalid (disp_rvalid),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
  );

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // Synchronous RAM model: read-before-write, output registered
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
      mem[16'h0010] = 16'hBEEF;
      mem[16'h0100] = 16'hC0DE;
      mem_loaded = 1'b1;
    end
    ram_q <= mem[ram_address];
    if (ram_wren) mem[ram_address] = ram_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [15:0] caddr,
                       input logic [15:0] cwd, input logic den, input logic dreq,
                       input logic [15:0] daddr);
    cpu_req   = creq;
    cpu_we    = cwe;
    cpu_addr  = caddr;
    cpu_wdata = cwd;
    disp_en   = den;
    disp_req  = dreq;
    disp_addr = daddr;
  endtask

  // One arbitration cycle: check grant outputs, push the expected response,
  // then pop and compare it one cycle later
  task automatic step(input string tag,
                      input logic creq, input logic cwe, input logic [15:0] caddr,
                      input logic [15:0] cwd, input logic den, input logic dreq,
                      input logic [15:0] daddr,
                      input logic x_stall, input logic x_ack, input logic x_wren,
                      input int x_wait, input int kind, input logic [15:0] x_data);
    exp_t e;
    drive(creq, cwe, caddr, cwd, den, dreq, daddr);
    #1;
    check({tag, ".stall"}, 32'(cpu_stall), 32'(x_stall));
    check({tag, ".ack"}, 32'(disp_ack), 32'(x_ack));
    check({tag, ".wren"}, 32'(ram_wren), 32'(x_wren));
    if (x_wait >= 0) check({tag, ".wait"}, 32'(dut.wait_cnt), 32'(x_wait));
    if (x_ack) check({tag, ".addr"}, 32'(ram_address), 32'(daddr));
    else if (creq && !x_stall) check({tag, ".addr"}, 32'(ram_address), 32'(caddr));
    if (x_wren) check({tag, ".wdata"}, 32'(ram_data), 32'(cwd));
    sb.push_back('{kind: kind, data: x_data});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".cpu_rvalid"}, 32'(cpu_rvalid), 32'(e.kind == K_CPU));
    check({tag, ".disp_rvalid"}, 32'(disp_rvalid), 32'(e.kind == K_DISP));
    if (e.kind == K_CPU) check({tag, ".cpu_rdata"}, 32'(cpu_rdata), 32'(e.data));
    if (e.kind == K_DISP) check({tag, ".disp_rdata"}, 32'(disp_rdata), 32'(e.data));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst.cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst.disp_rvalid", 32'(disp_rvalid), 32'd0);
    check("rst.disp_ack", 32'(disp_ack), 32'd0);
    check("rst.wait", 32'(dut.wait_cnt), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // CPU read, write, read back
    step("cpu_rd", 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 0, 0, 0, 0, K_CPU, 16'hBEEF);
    step("cpu_wr", 1, 1, 16'h0020, 16'h1234, 0, 0, 16'h0, 0, 0, 1, 0, K_NONE, 16'h0);
    step("cpu_rb", 1, 0, 16'h0020, 16'h0, 0, 0, 16'h0, 0, 0, 0, 0, K_CPU, 16'h1234);

    // Starvation: CPU wins four cycles, display wins the fifth
    for (int i = 0; i < 4; i++)
      step($sformatf("starve%0d", i), 1, 0, 16'(16'h0030 + i), 16'h0, 1, 1, 16'h0100,
           0, 0, 0, i, K_CPU, pat(16'(16'h0030 + i)));
    step("starve4", 1, 0, 16'h0034, 16'h0, 1, 1, 16'h0100, 1, 1, 0, 4, K_DISP, 16'hC0DE);
    step("starve5", 1, 0, 16'h0040, 16'h0, 1, 0, 16'h0100, 0, 0, 0, 0, K_CPU, pat(16'h0040));

    // Idle CPU: immediate display grants, alternating owners back to back
    step("idle0", 0, 0, 16'h0, 16'h0, 1, 1, 16'h0101, 0, 1, 0, 0, K_DISP, pat(16'h0101));
    step("idle1", 0, 0, 16'h0, 16'h0, 1, 1, 16'h0102, 0, 1, 0, 0, K_DISP, pat(16'h0102));
    step("alt_cpu", 1, 0, 16'h0041, 16'h0, 0, 0, 16'h0, 0, 0, 0, 0, K_CPU, pat(16'h0041));
    step("alt_disp", 0, 0, 16'h0, 16'h0, 1, 1, 16'h0103, 0, 1, 0, 0, K_DISP, pat(16'h0103));

    // Display disabled: requests ignored, counter held at zero
    for (int i = 0; i < 10; i++)
      step($sformatf("dis%0d", i), 1, 0, 16'(16'h0200 + i), 16'h0, 0, 1, 16'h0104,
           0, 0, 0, 0, K_CPU, pat(16'(16'h0200 + i)));
    step("dis_idle", 0, 0, 16'h0, 16'h0, 0, 1, 16'h0104, 0, 0, 0, 0, K_NONE, 16'h0);

    // disp_en falls while pending: counter clears, no ack
    step("fall0", 1, 0, 16'h0300, 16'h0, 1, 1, 16'h0105, 0, 0, 0, 0, K_CPU, pat(16'h0300));
    step("fall1", 1, 0, 16'h0301, 16'h0, 1, 1, 16'h0105, 0, 0, 0, 1, K_CPU, pat(16'h0301));
    step("fall2", 1, 0, 16'h0302, 16'h0, 0, 1, 16'h0105, 0, 0, 0, 2, K_CPU, pat(16'h0302));
    step("fall3", 1, 0, 16'h0303, 16'h0, 1, 1, 16'h0105, 0, 0, 0, 0, K_CPU, pat(16'h0303));

    // Reset right after a CPU read grant drops the pending rvalid
    step("pre0", 1, 0, 16'h0400, 16'h0, 1, 1, 16'h0106, 0, 0, 0, 1, K_CPU, pat(16'h0400));
    drive(1, 0, 16'h0401, 16'h0, 1, 1, 16'h0106);
    #1;
    check("pre1.stall", 32'(cpu_stall), 32'd0);
    check("pre1.wait", 32'(dut.wait_cnt), 32'd2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rstmid.cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rstmid.disp_rvalid", 32'(disp_rvalid), 32'd0);
    check("rstmid.wait", 32'(dut.wait_cnt), 32'd0);
    @(negedge clk);
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    @(posedge clk);
    #1;
    check("rsthold.cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step("post", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 0, 0, 0, 0, K_NONE, 16'h0);
    step("post_rd", 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 0, 0, 0, 0, K_CPU, 16'hBEEF);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port data RAM between the CPU memory stage and the display pixel fetcher. Each cycle the block selects one requester and drives the RAM address, data and write-enable from that requester. It returns the synchronous read data to the owner one cycle later. CPU requests have fixed priority; a saturating wait counter guarantees the display port a slot after a bounded delay.

## Interface
Parameters:
- ADDR_W, 16, RAM address width
- DATA_W, 16, RAM word width
- MAX_WAIT, 4, display wait cycles before it overrides CPU priority (1..15)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU memory-stage access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_stall  out  1  request present but not granted this cycle
- cpu_rdata  out  DATA_W  CPU read data
- cpu_rvalid  out  1  cpu_rdata valid (one-cycle pulse)
- disp_en  in  1  display fetch enabled (board switch)
- disp_req  in  1  display read request, held until disp_ack
- disp_addr  in  ADDR_W  pixel word address, stable while disp_req
- disp_ack  out  1  display request accepted this cycle
- disp_rdata  out  DATA_W  display read data
- disp_rvalid  out  1  disp_rdata valid (one-cycle pulse)
- ram_address  out  ADDR_W  to RAM (RAM registers it internally)
- ram_data  out  DATA_W  to RAM
- ram_wren  out  1  to RAM
- ram_q  in  DATA_W  RAM read data, valid one cycle after address

## Operation
- Grant (combinational each cycle):
  - starve = (wait_cnt == MAX_WAIT).
  - Display wins if disp_en & disp_req & (starve | !cpu_req).
  - Otherwise CPU wins if cpu_req.
  - Otherwise no grant.
- Winner drives ram_address; ram_wren = cpu_we only when CPU wins, else 0; ram_data = cpu_wdata whenever CPU wins, else 0.
- cpu_stall = cpu_req & !cpu_grant. disp_ack = disp_grant.
- wait_cnt (0..MAX_WAIT, saturating):
  - Increments when disp_en & disp_req & !disp_ack.
  - Clears on disp_ack or when !disp_en.
- Owner register, registered each cycle: OWN_NONE, OWN_CPU_RD or OWN_DISP. A CPU write records OWN_NONE.
- Next cycle:
  - cpu_rvalid = (owner == OWN_CPU_RD).
  - disp_rvalid = (owner == OWN_DISP).
  - cpu_rdata and disp_rdata are both driven from ram_q, and are meaningful only with their rvalid.
- With disp_en = 0, display requests are ignored: no ack, counter held at 0.

## Timing
- Reset values: cpu_rvalid = disp_rvalid = disp_ack = 0; owner = OWN_NONE; wait_cnt = 0. Combinational outputs follow their inputs.
- Read latency is 1 cycle: grant in cycle N gives rvalid and data in cycle N+1.
- Write completes at the granted edge; writes produce no rvalid.
- Back-to-back grants to alternating owners are allowed; throughput is one access per cycle.
- Simultaneous requests:
  - CPU wins while wait_cnt < MAX_WAIT.
  - At MAX_WAIT the display wins; CPU stalls that cycle and is granted the next cycle if the display does not request again.
  - Because the counter clears on ack, CPU cannot starve.
- If disp_en falls while disp_req is pending: no ack, counter clears.
- Reset asserted mid-operation: any pending rvalid is dropped (owner forced to OWN_NONE) and the counter clears immediately.

## Structure
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_CPU_RD, OWN_DISP}
  - default ADDR_W/DATA_W constants, shared with the RAM wrapper and the display fetcher
- Sub-module starve_counter: saturating counter with inc, clr, sat outputs, parameterised by MAX_WAIT.
- All remaining logic lives in ram_arbiter.

## Test plan
- CPU read only: cpu_req = 1, cpu_we = 0, cpu_addr = 0x0010, RAM[0x0010] = 0xBEEF -> no stall; next cycle cpu_rvalid = 1, cpu_rdata = 0xBEEF.
- CPU write then read: write 0x1234 to 0x0020, then read 0x0020 -> ram_wren = 1 for one cycle, no rvalid for the write; read returns 0x1234.
- Starvation, MAX_WAIT = 4: cpu_req held high, disp_req = 1 at 0x0100 -> cpu_stall = 0 for 4 cycles; cycle 5 disp_ack = 1 and cpu_stall = 1; cycle 6 disp_rvalid = 1 and cpu granted.
- Display idle CPU: cpu_req = 0, disp_req = 1 -> disp_ack in the same cycle, wait_cnt stays 0, data the next cycle.
- disp_en = 0 with disp_req = 1 for 10 cycles -> disp_ack never asserts, wait_cnt = 0, CPU unaffected.
- Reset pulse in the cycle after a CPU read grant -> cpu_rvalid = 0 during and after reset; wait_cnt = 0.
